// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: random wait, "go" indication, millisecond scoring,
// false-start detection and new-record flagging.
module reaction_game_ctrl #(
    parameter int TICK_DIV     = 50000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 11
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        start_btn,
    input  logic        react_btn,
    input  logic        new_hs,
    output logic [1:0]  state,
    output logic [13:0] current_score,
    output logic        go_led,
    output logic        false_start,
    output logic        new_record
);

    // state    | meaning
    // S_IDLE   | waiting for a start press; last result still shown
    // S_WAIT   | random delay running; a react press here is a false start
    // S_REACT  | go LED on; score counts ms until react press or timeout
    // S_RESULT | score frozen; start press returns to idle

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_REACT  = 2'd2,
        S_RESULT = 2'd3
    } state_t;

    localparam int          DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          DLY_W     = 16;
    localparam logic [13:0] SCORE_MAX = 14'd9999;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    state_t             r_state, w_state_nx;
    logic [13:0]        r_score, w_score_nx;
    logic [DLY_W-1:0]   r_delay, w_delay_nx;
    logic [DIV_W-1:0]   r_div, w_div_nx;
    logic               r_false_start, w_false_start_nx;
    logic               r_new_record, w_new_record_nx;
    logic               r_start_d, r_react_d;
    logic [15:0]        r_lfsr;

    logic               w_start_press, w_react_press, w_tick, w_lfsr_fb;
    logic [DLY_W-1:0]   w_delay_load;

    assign w_start_press = start_btn & ~r_start_d;
    assign w_react_press = react_btn & ~r_react_d;
    assign w_tick        = (r_div == DIV_W'(TICK_DIV - 1));
    assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_delay_load  = DLY_W'(MIN_DELAY_MS) + DLY_W'(r_lfsr[RAND_BITS-1:0]);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_state       <= S_IDLE;
            r_score       <= '0;
            r_delay       <= '0;
            r_div         <= '0;
            r_false_start <= 1'b0;
            r_new_record  <= 1'b0;
            r_start_d     <= 1'b0;
            r_react_d     <= 1'b0;
            r_lfsr        <= LFSR_SEED;
        end else begin
            r_state       <= w_state_nx;
            r_score       <= w_score_nx;
            r_delay       <= w_delay_nx;
            r_div         <= w_div_nx;
            r_false_start <= w_false_start_nx;
            r_new_record  <= w_new_record_nx;
            r_start_d     <= start_btn;
            r_react_d     <= react_btn;
            r_lfsr        <= {r_lfsr[14:0], w_lfsr_fb};
        end
    end

    always_comb begin
        w_state_nx       = r_state;
        w_score_nx       = r_score;
        w_delay_nx       = r_delay;
        w_false_start_nx = r_false_start;
        w_div_nx         = w_tick ? '0 : r_div + DIV_W'(1);

        case (r_state)
            S_IDLE: begin
                if (w_start_press) begin
                    w_delay_nx       = w_delay_load;
                    w_false_start_nx = 1'b0;
                    w_div_nx         = '0;
                    w_state_nx       = S_WAIT;
                end
            end
            S_WAIT: begin
                // a false start wins over a delay expiring in the same cycle
                if (w_react_press) begin
                    w_false_start_nx = 1'b1;
                    w_score_nx       = SCORE_MAX;
                    w_state_nx       = S_RESULT;
                end else if (w_tick) begin
                    if (r_delay <= DLY_W'(1)) begin
                        w_delay_nx = '0;
                        w_score_nx = '0;
                        w_div_nx   = '0;
                        w_state_nx = S_REACT;
                    end else begin
                        w_delay_nx = r_delay - DLY_W'(1);
                    end
                end
            end
            S_REACT: begin
                if (w_react_press) begin
                    w_state_nx = S_RESULT;
                end else if (w_tick) begin
                    if (r_score >= SCORE_MAX - 14'd1) begin
                        w_score_nx = SCORE_MAX;
                        w_state_nx = S_RESULT;
                    end else begin
                        w_score_nx = r_score + 14'd1;
                    end
                end
            end
            S_RESULT: begin
                if (w_start_press) begin
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        // looks at the next state so the flag drops together with leaving RESULT
        w_new_record_nx = (w_state_nx == S_RESULT) & new_hs & ~w_false_start_nx;
    end

    assign state         = r_state;
    assign current_score = r_score;
    assign go_led        = (r_state == S_REACT);
    assign false_start   = r_false_start;
    assign new_record    = r_new_record;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with a fast tick (4 clocks/ms) and short delays.
module tb_reaction_game_ctrl;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic        new_hs = 1'b0;
    logic [1:0]  state;
    logic [13:0] current_score;
    logic        go_led;
    logic        false_start;
    logic        new_record;

    int checks = 0;
    int fails  = 0;

    logic [15:0] m_lfsr;
    int          exp_d;

    reaction_game_ctrl #(
        .TICK_DIV(4),
        .MIN_DELAY_MS(3),
        .RAND_BITS(2)
    ) dut (
        .iCLK(iCLK),
        .iRST_N(iRST_N),
        .start_btn(start_btn),
        .react_btn(react_btn),
        .new_hs(new_hs),
        .state(state),
        .current_score(current_score),
        .go_led(go_led),
        .false_start(false_start),
        .new_record(new_record)
    );

    always #5 iCLK = ~iCLK;

    // reference 16-bit Fibonacci LFSR, taps 16,14,13,11, seed ACE1
    always @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) m_lfsr <= 16'hACE1;
        else         m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge iCLK);
            #1;
        end
    endtask

    task automatic press_start();
        start_btn = 1'b1;
        cyc(1);
        start_btn = 1'b0;
    endtask

    task automatic press_react();
        react_btn = 1'b1;
        cyc(1);
        react_btn = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] tgt, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            cyc(1);
            n++;
            if (state == tgt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        iRST_N = 1'b0;
        cyc(3);
        checks++;
        if ({state, current_score, go_led, false_start, new_record} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs: state=%0d score=%0d go=%0b fs=%0b nr=%0b, required all 0",
                     state, current_score, go_led, false_start, new_record);
        end
        iRST_N = 1'b1;
        cyc(2);
        press_react();
        cyc(1);
        checks++;
        if (state !== 2'd0) begin
            fails++;
            $display("FAIL react_in_idle: state=%0d required 0", state);
        end
    endtask

    task automatic test_wait_timing();
        int n;
        bit ok;
        new_hs = 1'b1;
        exp_d = 3 + int'(m_lfsr[1:0]);
        press_start();
        checks++;
        if (state !== 2'd1 || false_start !== 1'b0) begin
            fails++;
            $display("FAIL start_to_wait: state=%0d fs=%0b required 1/0", state, false_start);
        end
        wait_state(2'd2, 4 * exp_d + 8, n, ok);
        checks++;
        if (!ok || n != 4 * exp_d) begin
            fails++;
            $display("FAIL wait_length: cycles=%0d reached=%0b required %0d", n, ok, 4 * exp_d);
        end
        checks++;
        if (go_led !== 1'b1 || current_score !== 14'd0) begin
            fails++;
            $display("FAIL react_entry: go=%0b score=%0d required 1/0", go_led, current_score);
        end
    endtask

    task automatic test_react_press();
        cyc(28);
        checks++;
        if (current_score !== 14'd7 || state !== 2'd2) begin
            fails++;
            $display("FAIL score_count: score=%0d state=%0d required 7/2", current_score, state);
        end
        press_react();
        checks++;
        if (state !== 2'd3 || current_score !== 14'd7 || go_led !== 1'b0 || new_record !== 1'b1) begin
            fails++;
            $display("FAIL react_result: state=%0d score=%0d go=%0b nr=%0b required 3/7/0/1",
                     state, current_score, go_led, new_record);
        end
        cyc(20);
        press_react();
        cyc(1);
        checks++;
        if (state !== 2'd3 || current_score !== 14'd7) begin
            fails++;
            $display("FAIL result_hold: state=%0d score=%0d required 3/7", state, current_score);
        end
    endtask

    task automatic test_result_to_idle_held();
        start_btn = 1'b1;
        cyc(1);
        checks++;
        if (state !== 2'd0 || new_record !== 1'b0 || current_score !== 14'd7) begin
            fails++;
            $display("FAIL result_to_idle: state=%0d nr=%0b score=%0d required 0/0/7",
                     state, new_record, current_score);
        end
        cyc(5);
        checks++;
        if (state !== 2'd0) begin
            fails++;
            $display("FAIL held_start_idle: state=%0d required 0", state);
        end
        start_btn = 1'b0;
        cyc(2);
        start_btn = 1'b1;
        cyc(1);
        checks++;
        if (state !== 2'd1) begin
            fails++;
            $display("FAIL held_start_wait: state=%0d required 1", state);
        end
        cyc(6);
        start_btn = 1'b0;
        checks++;
        if (state !== 2'd1) begin
            fails++;
            $display("FAIL held_start_once: state=%0d required 1", state);
        end
    endtask

    task automatic test_false_start();
        cyc(2);
        press_react();
        cyc(1);
        checks++;
        if (state !== 2'd3 || false_start !== 1'b1 || current_score !== 14'd9999 || new_record !== 1'b0) begin
            fails++;
            $display("FAIL false_start: state=%0d fs=%0b score=%0d nr=%0b required 3/1/9999/0",
                     state, false_start, current_score, new_record);
        end
        cyc(2);
        press_start();
        checks++;
        if (state !== 2'd0 || false_start !== 1'b1 || current_score !== 14'd9999) begin
            fails++;
            $display("FAIL fs_hold_idle: state=%0d fs=%0b score=%0d required 0/1/9999",
                     state, false_start, current_score);
        end
        cyc(2);
        press_start();
        checks++;
        if (state !== 2'd1 || false_start !== 1'b0) begin
            fails++;
            $display("FAIL fs_clear: state=%0d fs=%0b required 1/0", state, false_start);
        end
    endtask

    task automatic test_same_cycle();
        int n;
        bit ok;
        wait_state(2'd2, 40, n, ok);
        checks++;
        if (!ok) begin
            fails++;
            $display("FAIL reach_react: state=%0d required 2", state);
        end
        cyc(7);
        checks++;
        if (current_score !== 14'd1) begin
            fails++;
            $display("FAIL pre_tick_score: score=%0d required 1", current_score);
        end
        press_react();
        checks++;
        if (state !== 2'd3 || current_score !== 14'd1) begin
            fails++;
            $display("FAIL press_with_tick: state=%0d score=%0d required 3/1", state, current_score);
        end
    endtask

    task automatic test_saturate();
        int n;
        bit ok;
        new_hs = 1'b0;
        cyc(2);
        press_start();
        cyc(2);
        press_start();
        wait_state(2'd2, 40, n, ok);
        wait_state(2'd3, 40100, n, ok);
        checks++;
        if (!ok || n != 39996) begin
            fails++;
            $display("FAIL timeout_length: cycles=%0d reached=%0b required 39996", n, ok);
        end
        checks++;
        if (current_score !== 14'd9999 || go_led !== 1'b0 || new_record !== 1'b0) begin
            fails++;
            $display("FAIL timeout_result: score=%0d go=%0b nr=%0b required 9999/0/0",
                     current_score, go_led, new_record);
        end
        cyc(10);
        checks++;
        if (current_score !== 14'd9999 || state !== 2'd3) begin
            fails++;
            $display("FAIL saturate_hold: score=%0d state=%0d required 9999/3", current_score, state);
        end
    endtask

    task automatic test_reset_mid_react();
        int n;
        bit ok;
        new_hs = 1'b1;
        cyc(2);
        press_start();
        cyc(2);
        exp_d = 3 + int'(m_lfsr[1:0]);
        press_start();
        wait_state(2'd2, 4 * exp_d + 8, n, ok);
        checks++;
        if (!ok || n != 4 * exp_d) begin
            fails++;
            $display("FAIL wait_length2: cycles=%0d reached=%0b required %0d", n, ok, 4 * exp_d);
        end
        cyc(10);
        #2;
        iRST_N = 1'b0;
        #1;
        checks++;
        if ({state, current_score, go_led, false_start, new_record} !== 19'd0) begin
            fails++;
            $display("FAIL async_reset: state=%0d score=%0d go=%0b fs=%0b nr=%0b, required all 0",
                     state, current_score, go_led, false_start, new_record);
        end
        cyc(2);
        iRST_N = 1'b1;
        cyc(2);
        exp_d = 3 + int'(m_lfsr[1:0]);
        press_start();
        checks++;
        if (state !== 2'd1) begin
            fails++;
            $display("FAIL start_after_reset: state=%0d required 1", state);
        end
        wait_state(2'd2, 4 * exp_d + 8, n, ok);
        checks++;
        if (!ok || n != 4 * exp_d) begin
            fails++;
            $display("FAIL wait_length3: cycles=%0d reached=%0b required %0d", n, ok, 4 * exp_d);
        end
    endtask

    initial begin
        test_reset();
        test_wait_timing();
        test_react_press();
        test_result_to_idle_held();
        test_false_start();
        test_same_cycle();
        test_saturate();
        test_reset_mid_react();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000, meaning iCLK cycles per 1 ms tick.
REQ-002 SHALL have parameter MIN_DELAY_MS, default 1000, meaning the minimum random wait in ms.
REQ-003 SHALL have parameter RAND_BITS, default 11, meaning the number of LFSR bits added to MIN_DELAY_MS (range 0..2^RAND_BITS-1 ms).
REQ-004 SHALL have port iCLK, input, 1, the single system clock; all logic rising-edge.
REQ-005 SHALL have port iRST_N, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start_btn, input, 1, start/continue button, level, already synchronised, active-high.
REQ-007 SHALL have port react_btn, input, 1, player reaction button, level, already synchronised, active-high.
REQ-008 SHALL have port new_hs, input, 1, from high-score store: 1 when current_score < stored high score.
REQ-009 SHALL have port state, output, 2, game phase: 0=IDLE, 1=WAIT, 2=REACT, 3=RESULT.
REQ-010 SHALL have port current_score, output, 14, reaction time in ms (0..9999).
REQ-011 SHALL have port go_led, output, 1, "react now" indicator.
REQ-012 SHALL have port false_start, output, 1, flags that react_btn was pressed during WAIT.
REQ-013 SHALL have port new_record, output, 1, flags that the current result beats the high score.

Function
REQ-014 SHALL rising-edge detect both buttons (press = btn & ~btn_d); only press pulses affect the FSM, so a held button acts once.
REQ-015 SHALL run a 16-bit Fibonacci LFSR, taps 16,14,13,11, advancing every cycle in every state, seed 16'hACE1; it SHALL never reach all-zero.
REQ-016 SHALL generate a 1-cycle ms tick when the divider reaches TICK_DIV-1; divider wraps to 0 then, and SHALL clear to 0 on entry to WAIT and to REACT.
REQ-017 IDLE: go_led=0; on start press, SHALL load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], clear false_start, and enter WAIT the next cycle.
REQ-018 WAIT: delay SHALL decrement by 1 per tick; on a tick with delay==1 (or delay==0), SHALL enter REACT with current_score=0 and go_led=1 from the next cycle.
REQ-019 WAIT: on react press, SHALL set false_start=1 and current_score=9999 and enter RESULT; react press takes priority over a same-cycle expiring tick.
REQ-020 REACT: current_score SHALL increment by 1 per tick, saturating at 9999; on reaching 9999 (timeout), SHALL enter RESULT.
REQ-021 REACT: on react press, SHALL enter RESULT with the score frozen; a same-cycle tick SHALL NOT increment the score.
REQ-022 RESULT: go_led=0; current_score held; new_record SHALL be registered as new_hs & ~false_start every RESULT cycle, and 0 in all other states.
REQ-023 RESULT: on start press, SHALL enter IDLE; the game restarts only on a further start press in IDLE (IDLE lasts at least 1 cycle so the store can reload).
REQ-024 start press in WAIT or REACT SHALL be ignored; react press in IDLE or RESULT SHALL be ignored.
REQ-025 current_score SHALL hold its last value through IDLE until cleared on REACT entry; false_start SHALL hold until the next IDLE->WAIT transition.

Reset
REQ-026 While iRST_N=0, SHALL force state=0, current_score=0, go_led=0, false_start=0, new_record=0, divider=0, delay=0, button history=0, LFSR=16'hACE1, asynchronously; reset mid-game SHALL abandon it with no partial output.
REQ-027 After iRST_N deasserts, the FSM SHALL act on the first start press edge detected after release.

Verification (TICK_DIV=4, MIN_DELAY_MS=3, RAND_BITS=2)
REQ-028 Reset, start press -> state 0->1; WAIT lasts (3+lfsr[1:0]) ticks, then state=2, go_led=1, current_score=0.
REQ-029 In REACT, react press after 7 ticks -> state=3, current_score=7; further ticks leave score at 7; new_hs=1 -> new_record=1.
REQ-030 react press during WAIT -> state=3, false_start=1, current_score=9999, new_record=0 even with new_hs=1.
REQ-031 No react press in REACT -> score saturates at 9999, state=3; react press and tick in the same REACT cycle -> score unchanged.
REQ-032 Hold start_btn high through IDLE->WAIT -> only one transition; start press in RESULT -> state=0, new_record=0, score held.
REQ-033 Assert iRST_N=0 mid-REACT -> all outputs 0, state=0 immediately, without waiting for a clock edge.
